// File: rtl/pipe_pkg.sv
// Shared types and constants for the F/D/E pipeline register bank.
package pipe_pkg;

   localparam int unsigned RESULT_SRC_W = 2;
   localparam int unsigned ALU_CTRL_W   = 3;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]             RD1;
      logic [31:0]             RD2;
      logic [31:0]             PC;
      logic [31:0]             PCPlus4;
      logic [31:0]             ImmExt;
      logic [4:0]              Rs1;
      logic [4:0]              Rs2;
      logic [4:0]              Rd;
      logic                    RegWrite;
      logic                    MemWrite;
      logic                    Jump;
      logic                    Branch;
      logic                    ALUSrc;
      logic [RESULT_SRC_W-1:0] ResultSrc;
      logic [ALU_CTRL_W-1:0]   ALUControl;
   } de_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } fd_t;

   typedef struct packed {
      logic valid;
      de_t  de;
   } de_reg_t;

endpackage

// File: rtl/pipe_regs_fde_flopenrc.sv
// Width-parameterised flop with synchronous reset, enable and synchronous clear.
// Clear outranks enable and loads the same value as reset.
module flopenrc #(
   parameter int unsigned       Width    = 32,
   parameter logic [Width-1:0]  ResetVal = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] q_q;

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         q_q <= ResetVal;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipe_regs_fde.sv
// PC, F/D and D/E pipeline registers with stall/flush handling and valid tracking.
// Optional stall/flush event counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_regs_fde
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        FlushE,
   input  logic [31:0] PCNextF,
   input  logic [31:0] InstrF,
   input  logic [31:0] PCPlus4F,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   input  de_t         de_in,
   output de_t         de_out,
   output logic        ValidE,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushDCnt,
   output logic [31:0] FlushECnt
);

   localparam fd_t FdBubble = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

   fd_t     fd_d, fd_q;
   de_reg_t de_d, de_q;

   flopenrc #(
      .Width    (32),
      .ResetVal (RESET_PC)
   ) u_pc_reg (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (!StallF),
      .clr_i   (1'b0),
      .d_i     (PCNextF),
      .q_o     (PCF)
   );

   assign fd_d = '{valid: 1'b1, instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};

   flopenrc #(
      .Width    ($bits(fd_t)),
      .ResetVal (FdBubble)
   ) u_fd_reg (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (!StallD),
      .clr_i   (FlushD),
      .d_i     (fd_d),
      .q_o     (fd_q)
   );

   assign InstrD   = fd_q.instr;
   assign PCD      = fd_q.pc;
   assign PCPlus4D = fd_q.pc_plus4;
   assign ValidD   = fd_q.valid;

   // E has no stall: it loads every cycle unless bubbled.
   assign de_d = '{valid: fd_q.valid, de: de_in};

   flopenrc #(
      .Width    ($bits(de_reg_t)),
      .ResetVal ('0)
   ) u_de_reg (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (1'b1),
      .clr_i   (FlushE),
      .d_i     (de_d),
      .q_o     (de_q)
   );

   assign de_out = de_q.de;
   assign ValidE = de_q.valid;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flushd_cnt_q, flushd_cnt_d;
   logic [31:0] flushe_cnt_q, flushe_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flushd_cnt_d = flushd_cnt_q;
      flushe_cnt_d = flushe_cnt_q;
      if (StallF || StallD) stall_cnt_d = stall_cnt_q + 32'd1;
      if (FlushD)           flushd_cnt_d = flushd_cnt_q + 32'd1;
      // Only squashes of a real instruction count, not bubbles being bubbled.
      if (FlushE && fd_q.valid) flushe_cnt_d = flushe_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= 32'h0;
         flushd_cnt_q <= 32'h0;
         flushe_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flushd_cnt_q <= flushd_cnt_d;
         flushe_cnt_q <= flushe_cnt_d;
      end
   end

   assign StallCnt  = stall_cnt_q;
   assign FlushDCnt = flushd_cnt_q;
   assign FlushECnt = flushe_cnt_q;
`else
   assign StallCnt  = 32'h0;
   assign FlushDCnt = 32'h0;
   assign FlushECnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Table-driven bench for pipe_regs_fde; counter checks adapt to PIPE_PERF_CNT_EN.
module tb_pipe_regs_fde;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset, StallF, StallD, FlushD, FlushE;
   logic [31:0] PCNextF, InstrF, PCPlus4F;
   logic [31:0] PCF, InstrD, PCD, PCPlus4D;
   logic        ValidD, ValidE;
   de_t         de_in, de_out;
   logic [31:0] StallCnt, FlushDCnt, FlushECnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference counters and valid-D model.
   logic [31:0] m_stall = 32'h0, m_fd = 32'h0, m_fe = 32'h0;
   logic        m_vd = 1'b0;

   always #5 clk = ~clk;

   pipe_regs_fde dut (
      .clk       (clk),
      .reset     (reset),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .PCNextF   (PCNextF),
      .InstrF    (InstrF),
      .PCPlus4F  (PCPlus4F),
      .PCF       (PCF),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD),
      .de_in     (de_in),
      .de_out    (de_out),
      .ValidE    (ValidE),
      .StallCnt  (StallCnt),
      .FlushDCnt (FlushDCnt),
      .FlushECnt (FlushECnt)
   );

   // ctl = {reset, StallF, StallD, FlushD, FlushE}; e_flags = {ValidD, bubble, ValidE}
   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] pcn;
      logic [31:0] instr;
      logic [7:0]  tag;
      logic [31:0] e_pcf;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
      logic [2:0]  e_flags;
      logic [7:0]  e_tag;
   } vec_t;

   vec_t vecs[16];

   function automatic de_t make_de(input logic [7:0] t);
      de_t d;
      d.RD1        = {24'h110000, t};
      d.RD2        = {24'h220000, t};
      d.PC         = {24'h330000, t};
      d.PCPlus4    = {24'h440000, t};
      d.ImmExt     = {24'h550000, t};
      d.Rs1        = t[4:0];
      d.Rs2        = t[4:0] ^ 5'h1F;
      d.Rd         = t[4:0] + 5'd1;
      d.RegWrite   = t[0];
      d.MemWrite   = t[1];
      d.Jump       = t[2];
      d.Branch     = t[3];
      d.ALUSrc     = 1'b1;
      d.ResultSrc  = t[1:0];
      d.ALUControl = t[2:0];
      return d;
   endfunction

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [4:0] ctl, input logic [31:0] pcn, input logic [31:0] instr,
                       input logic [7:0] tag);
      @(negedge clk);
      {reset, StallF, StallD, FlushD, FlushE} = ctl;
      PCNextF  = pcn;
      InstrF   = instr;
      PCPlus4F = instr + 32'h1000;
      de_in    = make_de(tag);
      if (ctl[4]) begin
         m_stall = 32'h0; m_fd = 32'h0; m_fe = 32'h0; m_vd = 1'b0;
      end else begin
         if (ctl[3] || ctl[2]) m_stall = m_stall + 32'd1;
         if (ctl[1])           m_fd    = m_fd + 32'd1;
         if (ctl[0] && m_vd)   m_fe    = m_fe + 32'd1;
         if (ctl[1])           m_vd    = 1'b0;
         else if (!ctl[2])     m_vd    = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnts();
`ifdef PIPE_PERF_CNT_EN
      check("StallCnt", {160'h0, StallCnt}, {160'h0, m_stall});
      check("FlushDCnt", {160'h0, FlushDCnt}, {160'h0, m_fd});
      check("FlushECnt", {160'h0, FlushECnt}, {160'h0, m_fe});
`else
      check("StallCnt", {160'h0, StallCnt}, 192'h0);
      check("FlushDCnt", {160'h0, FlushDCnt}, 192'h0);
      check("FlushECnt", {160'h0, FlushECnt}, 192'h0);
`endif
   endtask

   initial begin
      reset = 1'b1; StallF = 1'b1; StallD = 1'b0; FlushD = 1'b1; FlushE = 1'b0;
      PCNextF = 32'h0; InstrF = 32'h0; PCPlus4F = 32'h0; de_in = '0;

      vecs[0]  = '{5'b11010, 32'h44,  32'h55, 8'h01, 32'h0,   32'h13, 32'h0,   3'b010, 8'h00};
      vecs[1]  = '{5'b11010, 32'h44,  32'h55, 8'h01, 32'h0,   32'h13, 32'h0,   3'b010, 8'h00};
      vecs[2]  = '{5'b11010, 32'h44,  32'h55, 8'h01, 32'h0,   32'h13, 32'h0,   3'b010, 8'h00};
      vecs[3]  = '{5'b00000, 32'h4,   32'hA0, 8'h10, 32'h4,   32'hA0, 32'h0,   3'b100, 8'h10};
      vecs[4]  = '{5'b00000, 32'h8,   32'hA1, 8'h11, 32'h8,   32'hA1, 32'h4,   3'b101, 8'h11};
      vecs[5]  = '{5'b00000, 32'hC,   32'hA2, 8'h12, 32'hC,   32'hA2, 32'h8,   3'b101, 8'h12};
      vecs[6]  = '{5'b01101, 32'h10,  32'hA3, 8'h13, 32'hC,   32'hA2, 32'h8,   3'b110, 8'h00};
      vecs[7]  = '{5'b00000, 32'h10,  32'hA3, 8'h14, 32'h10,  32'hA3, 32'hC,   3'b101, 8'h14};
      vecs[8]  = '{5'b00011, 32'h100, 32'hA4, 8'h15, 32'h100, 32'h13, 32'h0,   3'b010, 8'h00};
      vecs[9]  = '{5'b00000, 32'h104, 32'hB0, 8'h16, 32'h104, 32'hB0, 32'h100, 3'b100, 8'h16};
      vecs[10] = '{5'b00110, 32'h108, 32'hB1, 8'h17, 32'h108, 32'h13, 32'h0,   3'b001, 8'h17};
      vecs[11] = '{5'b01100, 32'h10C, 32'hB2, 8'h18, 32'h108, 32'h13, 32'h0,   3'b000, 8'h18};
      vecs[12] = '{5'b00000, 32'h10C, 32'hB2, 8'h19, 32'h10C, 32'hB2, 32'h108, 3'b100, 8'h19};
      vecs[13] = '{5'b11100, 32'h200, 32'hC0, 8'h1A, 32'h0,   32'h13, 32'h0,   3'b010, 8'h00};
      vecs[14] = '{5'b00000, 32'h4,   32'hC1, 8'h1B, 32'h4,   32'hC1, 32'h0,   3'b100, 8'h1B};
      vecs[15] = '{5'b00001, 32'h8,   32'hC2, 8'h1C, 32'h8,   32'hC2, 32'h4,   3'b110, 8'h00};

      for (int i = 0; i < 16; i++) begin
         logic [31:0] e_p4;
         de_t         e_de;
         step(vecs[i].ctl, vecs[i].pcn, vecs[i].instr, vecs[i].tag);
         e_p4 = vecs[i].e_flags[2] ? vecs[i].e_instr + 32'h1000 : 32'h0;
         e_de = vecs[i].e_flags[1] ? '0 : make_de(vecs[i].e_tag);
         check("PCF", {160'h0, PCF}, {160'h0, vecs[i].e_pcf});
         check("InstrD", {160'h0, InstrD}, {160'h0, vecs[i].e_instr});
         check("PCD", {160'h0, PCD}, {160'h0, vecs[i].e_pcd});
         check("PCPlus4D", {160'h0, PCPlus4D}, {160'h0, e_p4});
         check("ValidD", {191'h0, ValidD}, {191'h0, vecs[i].e_flags[2]});
         check("de_out", {7'h0, de_out}, {7'h0, e_de});
         check("ValidE", {191'h0, ValidE}, {191'h0, vecs[i].e_flags[0]});
         check_cnts();
      end

      // Load-use stall then release: one bubble, then the held instruction reaches E.
      step(5'b01101, 32'hC, 32'hC3, 8'h20);
      check("lu_PCF", {160'h0, PCF}, {160'h0, 32'h8});
      check("lu_InstrD", {160'h0, InstrD}, {160'h0, 32'hC2});
      check("lu_de_out", {7'h0, de_out}, 192'h0);
      check("lu_ValidE", {191'h0, ValidE}, 192'h0);
      check_cnts();
      step(5'b00000, 32'hC, 32'hC3, 8'h21);
      check("rel_PCF", {160'h0, PCF}, {160'h0, 32'hC});
      check("rel_InstrD", {160'h0, InstrD}, {160'h0, 32'hC3});
      check("rel_PCD", {160'h0, PCD}, {160'h0, 32'h8});
      check("rel_de_out", {7'h0, de_out}, {7'h0, make_de(8'h21)});
      check("rel_ValidE", {191'h0, ValidE}, {191'h0, 1'b1});
      check_cnts();

`ifdef PIPE_PERF_CNT_EN
      // Stall counter wrap from all-ones.
      @(negedge clk);
      StallF = 1'b1; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      @(posedge clk);
      #1;
      check("StallCnt_wrap", {160'h0, StallCnt}, 192'h0);
`else
      for (int i = 0; i < 8; i++) begin
         step({1'b0, 4'($urandom_range(0, 15))}, $urandom, $urandom, 8'($urandom));
         check_cnts();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
